// File: rtl/video_pkg.sv
// Shared constants, FSM encoding and glyph helpers for the HDMI text overlay path.
package video_pkg;

  localparam int CELL_W  = 10;
  localparam int CELL_H  = 14;
  localparam int GLYPH_W = 5;
  localparam int GLYPH_H = 7;

  localparam logic [7:0] CLEAR_CHAR = 8'h20;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // glyph[y][x]: y=0 is the top row, x=0 is the leftmost column.
  typedef logic [GLYPH_H-1:0][GLYPH_W-1:0] glyph_t;

  // Turns "ASCII art" (top row in the MSBs, leftmost pixel first) into glyph_t indexing.
  function automatic glyph_t art_to_glyph(input logic [GLYPH_W*GLYPH_H-1:0] art);
    glyph_t g;
    for (int y = 0; y < GLYPH_H; y++) begin
      for (int x = 0; x < GLYPH_W; x++) begin
        g[y][x] = art[GLYPH_W*GLYPH_H-1 - y*GLYPH_W - x];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/ascii_tbl.sv
// 5x7 glyph lookup for the printable characters used on the status overlay.
module ascii_tbl
  import video_pkg::*;
(
  input  logic [7:0] code,
  output glyph_t     glyph
);

  // NOTE: every combinational output gets a default first, so no code path can infer a latch.
  always_comb begin
    glyph = '0;
    case (code)
      8'h30: glyph = art_to_glyph({5'b01110, 5'b10001, 5'b10011, 5'b10101,
                                   5'b11001, 5'b10001, 5'b01110});
      8'h31: glyph = art_to_glyph({5'b00100, 5'b01100, 5'b00100, 5'b00100,
                                   5'b00100, 5'b00100, 5'b01110});
      8'h32: glyph = art_to_glyph({5'b01110, 5'b10001, 5'b00001, 5'b00010,
                                   5'b00100, 5'b01000, 5'b11111});
      8'h41: glyph = art_to_glyph({5'b01110, 5'b10001, 5'b10001, 5'b11111,
                                   5'b10001, 5'b10001, 5'b10001});
      8'h42: glyph = art_to_glyph({5'b11110, 5'b10001, 5'b10001, 5'b11110,
                                   5'b10001, 5'b10001, 5'b11110});
      8'h43: glyph = art_to_glyph({5'b01110, 5'b10001, 5'b10000, 5'b10000,
                                   5'b10000, 5'b10001, 5'b01110});
      default: glyph = '0;
    endcase
  end

endmodule

// File: rtl/text_char_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
module text_char_ram #(
  parameter int DEPTH  = 6528,
  parameter int ADDR_W = 13
) (
  input  logic              clk_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: neither the array nor the read register is reset, so this maps onto block RAM.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_in) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/text_overlay.sv
// Full-screen character-cell overlay between the frame-buffer RGB path and the TMDS encoders.
// Fixed 2-cycle latency; hsync/vsync/active-draw must be delayed to match outside this block.
module text_overlay
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int COLS     = 128,
  parameter int ROWS     = 51,
  parameter int ADDR_W   = 13
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [7:0]        red_in,
  input  logic [7:0]        green_in,
  input  logic [7:0]        blue_in,
  input  logic [23:0]       fg_rgb_in,
  input  logic              wr_en_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [7:0]        wr_data_in,
  input  logic              clear_in,
  output logic              busy_out,
  output logic [7:0]        red_out,
  output logic [7:0]        green_out,
  output logic [7:0]        blue_out,
  output logic              lit_out
);

  localparam int DEPTH  = COLS * ROWS;
  localparam int TEXT_W = (COLS * CELL_W <= H_ACTIVE) ? COLS * CELL_W : H_ACTIVE;
  localparam int TEXT_H = (ROWS * CELL_H <= V_ACTIVE) ? ROWS * CELL_H : V_ACTIVE;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [10:0]       TEXT_W_H  = 11'(TEXT_W);
  localparam logic [9:0]        TEXT_H_V  = 10'(TEXT_H);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COLS - 1);
  localparam logic [3:0]        X_MAX     = 4'(CELL_W - 1);
  localparam logic [3:0]        Y_MAX     = 4'(CELL_H - 1);

  // ---------------- clear / write FSM ----------------
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_addr_in;
    ram_wdata  = wr_data_in;
    busy_out   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_in) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end else if (wr_en_in && ({1'b0, wr_addr_in} < DEPTH_L)) begin
          ram_we = 1'b1;
        end
      end
      CLEAR: begin
        busy_out  = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = clr_addr_q;
        ram_wdata = CLEAR_CHAR;
        if (clr_addr_q == LAST_ADDR) state_d = IDLE;
        else                         clr_addr_d = clr_addr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // ---------------- scan position tracking ----------------
  // Counters hold the position of the next pixel; hcount/vcount zero override them.
  logic [3:0]       cell_x_q, cell_x, cell_y_q, cell_y;
  logic [COL_W-1:0] char_col_q, char_col;
  logic [ROW_W-1:0] char_row_q, char_row;
  logic             h_zero;

  assign h_zero = (hcount_in == '0);

  always_comb begin
    cell_x   = h_zero ? '0 : cell_x_q;
    char_col = h_zero ? '0 : char_col_q;
    cell_y   = cell_y_q;
    char_row = char_row_q;
    if (h_zero) begin
      if (vcount_in == '0) begin
        cell_y   = '0;
        char_row = '0;
      end else if (vcount_in < TEXT_H_V) begin
        if (cell_y_q == Y_MAX) begin
          cell_y   = '0;
          char_row = char_row_q + 1'b1;
        end else begin
          cell_y = cell_y_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cell_x_q   <= '0;
      char_col_q <= '0;
      cell_y_q   <= '0;
      char_row_q <= '0;
    end else begin
      cell_y_q   <= cell_y;
      char_row_q <= char_row;
      cell_x_q   <= cell_x;
      char_col_q <= char_col;
      if (hcount_in < TEXT_W_H) begin
        if (cell_x == X_MAX) begin
          cell_x_q <= '0;
          if (char_col != COL_MAX) char_col_q <= char_col + 1'b1;
        end else begin
          cell_x_q <= cell_x + 1'b1;
        end
      end
    end
  end

  // ---------------- stage 1: character RAM read + side-band registers ----------------
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        code_q;
  logic              in_text;
  logic [3:0]        cell_x_d, cell_y_d;
  logic              in_text_d;
  logic [23:0]       rgb_d, fg_d;

  // With COLS a power of two the multiply reduces to a shift.
  assign rd_addr = ADDR_W'(char_row) * ADDR_W'(COLS) + ADDR_W'(char_col);
  assign in_text = en_in && (hcount_in < TEXT_W_H) && (vcount_in < TEXT_H_V);

  text_char_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_char_ram (
    .clk_in  (clk_in),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (rd_addr),
    .rd_data (code_q)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cell_x_d  <= '0;
      cell_y_d  <= '0;
      in_text_d <= 1'b0;
      rgb_d     <= '0;
      fg_d      <= '0;
    end else begin
      cell_x_d  <= cell_x;
      cell_y_d  <= cell_y;
      in_text_d <= in_text;
      rgb_d     <= {red_in, green_in, blue_in};
      fg_d      <= fg_rgb_in;
    end
  end

  // ---------------- stage 2: glyph lookup and composite ----------------
  glyph_t glyph;
  logic   lit;

  ascii_tbl u_ascii_tbl (
    .code  (code_q),
    .glyph (glyph)
  );

  // Each glyph pixel covers a 2x2 block of screen pixels.
  assign lit = in_text_d && glyph[cell_y_d[3:1]][cell_x_d[3:1]];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
      lit_out   <= 1'b0;
    end else begin
      {red_out, green_out, blue_out} <= lit ? fg_d : rgb_d;
      lit_out                        <= lit;
    end
  end

endmodule
